mmio_timer: RTL



---
 rtl/mmio_timer_if.sv | 23 ++
 rtl/mmio_timer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mmio_timer_if.sv
// Load/store bus between the core (master) and a memory-mapped responder (slave).
// One request per cycle on en; the responder answers with a one-cycle ready strobe.
interface mmio_timer_if;
  logic        en;
  logic        write;
  logic [1:0]  width;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        addr_fault;
  logic        access_fault;

  modport master (
    output en, write, width, addr, wdata,
    input  rdata, ready, addr_fault, access_fault
  );

  modport slave (
    input  en, write, width, addr, wdata,
    output rdata, ready, addr_fault, access_fault
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: prescaled 64-bit MTIME, 64-bit MTIMECMP, level ext_int.
// Define MMIO_TIMER_LATCH_EN to latch MTIME_HI on every MTIME_LO read for coherent 64-bit reads.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hC000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  mmio_timer_if.slave bus,
  output logic        ext_int
);
  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        ctrl_en;
  logic        ctrl_ie;
  logic [7:0]  prescale;
  logic [7:0]  pre_cnt;
`ifdef MMIO_TIMER_LATCH_EN
  logic [31:0] mtime_hi_shadow;
`endif

  logic        sel;
  logic [2:0]  word_off;
  logic        width_bad;
  logic        misaligned;
  logic        target_bad;
  logic        rd_ok;
  logic        wr_ok;
  logic        tick;
  logic        cmp_hit;
  logic [31:0] rd_mux;

  logic        vld_p1;
  logic        addr_fault_p1;
  logic        access_fault_p1;
  logic [31:0] rdata_p1;

  // p0: request decode, fault classification and read mux (all from pre-update state)
  always_comb begin
    sel        = bus.en && (bus.addr[31:5] == BASE_ADDR[31:5]);
    word_off   = bus.addr[4:2];
    width_bad  = (bus.width != 2'b10);
    misaligned = (bus.addr[1:0] != 2'b00);
    target_bad = (word_off > OFF_STATUS) || (bus.write && word_off == OFF_STATUS);
    rd_ok      = sel && !width_bad && !misaligned && !target_bad && !bus.write;
    wr_ok      = sel && !width_bad && !misaligned && !target_bad && bus.write;
    tick       = ctrl_en && (pre_cnt == prescale);
    cmp_hit    = (mtime >= mtimecmp);

    rd_mux = 32'd0;
    case (word_off)
      OFF_MTIME_LO: rd_mux = mtime[31:0];
`ifdef MMIO_TIMER_LATCH_EN
      OFF_MTIME_HI: rd_mux = mtime_hi_shadow;
`else
      OFF_MTIME_HI: rd_mux = mtime[63:32];
`endif
      OFF_CMP_LO:   rd_mux = mtimecmp[31:0];
      OFF_CMP_HI:   rd_mux = mtimecmp[63:32];
      OFF_CTRL:     rd_mux = {16'd0, prescale, 6'd0, ctrl_ie, ctrl_en};
      OFF_STATUS:   rd_mux = {31'd0, cmp_hit};
      default:      rd_mux = 32'd0;
    endcase
  end

  // p0 -> p1: response registers, interrupt, and register-file state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1          <= 1'b0;
      addr_fault_p1   <= 1'b0;
      access_fault_p1 <= 1'b0;
      rdata_p1        <= 32'd0;
      ext_int         <= 1'b0;
      mtime           <= 64'd0;
      mtimecmp        <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl_en         <= 1'b0;
      ctrl_ie         <= 1'b0;
      prescale        <= 8'd0;
      pre_cnt         <= 8'd0;
`ifdef MMIO_TIMER_LATCH_EN
      mtime_hi_shadow <= 32'd0;
`endif
    end else begin
      vld_p1          <= sel;
      addr_fault_p1   <= sel && !width_bad && misaligned;
      access_fault_p1 <= sel && (width_bad || (!misaligned && target_bad));
      rdata_p1        <= rd_ok ? rd_mux : 32'd0;
      ext_int         <= ctrl_ie && cmp_hit;

      if (wr_ok && word_off == OFF_CTRL) begin
        ctrl_en  <= bus.wdata[0];
        ctrl_ie  <= bus.wdata[1];
        prescale <= bus.wdata[15:8];
        pre_cnt  <= 8'd0;
      end else if (tick) begin
        pre_cnt  <= 8'd0;
      end else if (ctrl_en) begin
        pre_cnt  <= pre_cnt + 8'd1;
      end

      // A bus write to either half suppresses that cycle's increment entirely.
      if (wr_ok && word_off == OFF_MTIME_LO) begin
        mtime[31:0] <= bus.wdata;
      end else if (wr_ok && word_off == OFF_MTIME_HI) begin
        mtime[63:32] <= bus.wdata;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_ok && word_off == OFF_CMP_LO) mtimecmp[31:0]  <= bus.wdata;
      if (wr_ok && word_off == OFF_CMP_HI) mtimecmp[63:32] <= bus.wdata;

`ifdef MMIO_TIMER_LATCH_EN
      if (wr_ok && word_off == OFF_MTIME_HI)
        mtime_hi_shadow <= bus.wdata;
      else if (rd_ok && word_off == OFF_MTIME_LO)
        mtime_hi_shadow <= mtime[63:32];
`endif
    end
  end

  assign bus.ready        = vld_p1;
  assign bus.rdata        = rdata_p1;
  assign bus.addr_fault   = addr_fault_p1;
  assign bus.access_fault = access_fault_p1;
endmodule
